ram_load_arbiter: RTL and testbench

RAM_LOAD_ARBITER -- requirements
Module: ram_load_arbiter

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/ram_load_arbiter_if.sv | 26 ++
 rtl/ram_load_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_load_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and defaults for the RAM load arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int unsigned c_ADR_W = 24;
    localparam int unsigned c_DAT_W = 32;
    localparam int unsigned c_SEL_W = 4;

    localparam int unsigned          c_ERASE_WORDS_DEFAULT = 1048576;
    localparam logic [c_ADR_W-1:0]   c_ROM_BASE_DEFAULT    = 24'h100000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_ERASE  = 3'd2,
        S_LOAD   = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd5
    } arb_state_t;

    // Byte lanes for a halfword write; bit 1 of the byte address picks the upper half.
    function automatic logic [c_SEL_W-1:0] halfword_sel(input logic upper);
        return upper ? 4'b1100 : 4'b0011;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_load_arbiter_if.sv
// ============================================================================
// Module      : ram_load_arbiter_if
// Description : Wishbone-style write bus used on both core and RAM sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_load_arbiter_if;
    import ram_arb_pkg::*;

    logic               cyc;
    logic               stb;
    logic               we;
    logic [c_SEL_W-1:0] sel;
    logic [c_ADR_W-1:0] adr;
    logic [c_DAT_W-1:0] dat;
    logic               ack;

    modport master (output cyc, output stb, output we, output sel,
                    output adr, output dat, input  ack);

    modport slave  (input  cyc, input  stb, input  we, input  sel,
                    input  adr, input  dat, output ack);
endinterface

`default_nettype wire

// File: rtl/ram_load_arbiter.sv
// ============================================================================
// Module      : ram_load_arbiter
// Description : Shares the SDRAM port between the core and a ROM downloader,
//               zeroing RAM before the image is written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_load_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned        ERASE_WORDS = c_ERASE_WORDS_DEFAULT,
    parameter logic [c_ADR_W-1:0] ROM_BASE    = c_ROM_BASE_DEFAULT
) (
    input  wire logic          clk_sys,
    input  wire logic          reset,
    input  wire logic          dl_active,
    input  wire logic          dl_wr,
    input  wire logic [21:0]   dl_addr,
    input  wire logic [15:0]   dl_data,
    output logic               dl_wait,
    output logic               dl_err,
    output logic               core_hold,
    ram_load_arbiter_if.slave  core,
    ram_load_arbiter_if.master ram
);

    localparam logic [c_ADR_W-1:0] c_ERASE_LAST = c_ADR_W'(ERASE_WORDS - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_dl_active_d;
    logic [c_ADR_W-1:0]  r_erase_cnt;
    logic [20:0]         r_wr_addr;
    logic [15:0]         r_wr_data;
    logic                r_dl_err;

    logic                w_dl_rise;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_latch;

    // Halfword granularity only; the byte-lane bit of the address is meaningless here.
    wire logic w_unused_ok = dl_addr[0];

    assign w_dl_rise = dl_active & ~r_dl_active_d;
    assign dl_err    = r_dl_err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_latch     = 1'b0;
        dl_wait     = 1'b1;
        core_hold   = 1'b1;
        core.ack    = 1'b0;
        ram.cyc     = 1'b0;
        ram.stb     = 1'b0;
        ram.we      = 1'b0;
        ram.sel     = '0;
        ram.adr     = '0;
        ram.dat     = '0;

        case (r_state)
            S_IDLE: begin
                ram.cyc   = core.cyc;
                ram.stb   = core.stb;
                ram.we    = core.we;
                ram.sel   = core.sel;
                ram.adr   = core.adr;
                ram.dat   = core.dat;
                core.ack  = ram.ack;
                core_hold = 1'b0;
                dl_wait   = w_dl_rise;
                if (w_dl_rise) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = core.cyc ? S_DRAIN : S_ERASE;
                end
            end

            S_DRAIN: begin
                // Only the access already on the bus is allowed to finish.
                ram.cyc   = core.cyc;
                ram.stb   = core.stb;
                ram.we    = core.we;
                ram.sel   = core.sel;
                ram.adr   = core.adr;
                ram.dat   = core.dat;
                core.ack  = ram.ack;
                core_hold = 1'b0;
                if (ram.ack || !core.cyc) begin
                    w_state_nxt = dl_active ? S_ERASE : S_FINISH;
                end
            end

            S_ERASE: begin
                ram.cyc = 1'b1;
                ram.stb = 1'b1;
                ram.we  = 1'b1;
                ram.sel = 4'b1111;
                ram.adr = r_erase_cnt;
                if (ram.ack) begin
                    if (!dl_active) begin
                        w_state_nxt = S_FINISH;
                    end else if (r_erase_cnt == c_ERASE_LAST) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                dl_wait = 1'b0;
                // A strobe coinciding with dl_active falling is still honoured.
                if (dl_wr) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_WRITE;
                end else if (!dl_active) begin
                    w_state_nxt = S_FINISH;
                end
            end

            S_WRITE: begin
                ram.cyc = 1'b1;
                ram.stb = 1'b1;
                ram.we  = 1'b1;
                ram.sel = halfword_sel(r_wr_addr[0]);
                ram.adr = ROM_BASE + {4'b0000, r_wr_addr[20:1]};
                ram.dat = {r_wr_data, r_wr_data};
                if (ram.ack) begin
                    w_state_nxt = dl_active ? S_LOAD : S_FINISH;
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_active_d <= 1'b0;
            r_erase_cnt   <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_dl_err      <= 1'b0;
        end else begin
            r_dl_active_d <= dl_active;
            if (w_cnt_clr) begin
                r_erase_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_erase_cnt <= r_erase_cnt + 24'd1;
            end
            if (w_latch) begin
                r_wr_addr <= dl_addr[21:1];
                r_wr_data <= dl_data;
            end
            if (dl_wr && dl_wait) begin
                r_dl_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_load_arbiter.sv
// ============================================================================
// Module      : tb_ram_load_arbiter
// Description : Self-checking bench for ram_load_arbiter with a RAM responder
//               and a halfword memory-image reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_load_arbiter;

    localparam int unsigned EW = 4;
    localparam logic [23:0] RB = 24'h100000;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [23:0] adr;
        logic [31:0] dat;
    } acc_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [21:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait;
    logic        dl_err;
    logic        core_hold;

    ram_load_arbiter_if core_bus();
    ram_load_arbiter_if ram_bus();

    ram_load_arbiter #(.ERASE_WORDS(EW), .ROM_BASE(RB)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .dl_err    (dl_err),
        .core_hold (core_hold),
        .core      (core_bus),
        .ram       (ram_bus)
    );

    always #5 clk_sys = ~clk_sys;

    int   vectors    = 0;
    int   miscompares = 0;
    acc_t log_q[$];
    int   ack_delay  = 2;
    bit   resp_en    = 1'b0;
    int   resp_cnt   = 0;

    // RAM model: one-cycle ack after ack_delay cycles of a held request; logs completed accesses.
    always @(negedge clk_sys) begin
        if (!resp_en || ram_bus.ack === 1'b1) begin
            ram_bus.ack = 1'b0;
            resp_cnt    = 0;
        end else if (ram_bus.cyc === 1'b1 && ram_bus.stb === 1'b1) begin
            resp_cnt++;
            if (resp_cnt >= ack_delay) begin
                ram_bus.ack = 1'b1;
                log_q.push_back({ram_bus.we, ram_bus.sel, ram_bus.adr, ram_bus.dat});
            end
        end else begin
            resp_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic core_idle();
        core_bus.cyc = 1'b0; core_bus.stb = 1'b0; core_bus.we = 1'b0;
        core_bus.sel = 4'h0; core_bus.adr = 24'h0; core_bus.dat = 32'h0;
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (dl_active && !dl_wait && core_hold) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!core_hold && !dl_wait) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_session(output bit ok);
        resp_en   = 1'b1;
        ack_delay = 2;
        log_q.delete();
        dl_active = 1'b1;
        wait_load(ok);
    endtask

    task automatic test_reset();
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        bit          seen;
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        core_idle();
        resp_en = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++; if (dl_wait !== 1'b0) begin miscompares++; $display("FAIL reset_dl_wait: got %0b expected 0", dl_wait); end
        vectors++; if (dl_err !== 1'b0) begin miscompares++; $display("FAIL reset_dl_err: got %0b expected 0", dl_err); end
        vectors++; if (core_hold !== 1'b0) begin miscompares++; $display("FAIL reset_core_hold: got %0b expected 0", core_hold); end
        vectors++; if ({ram_bus.cyc, ram_bus.stb, ram_bus.we} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ram_ctl: got %b expected 000", {ram_bus.cyc, ram_bus.stb, ram_bus.we}); end
        for (int i = 0; i < 4; i++) begin
            a = 24'($urandom); d = $urandom; s = 4'($urandom); w = 1'($urandom);
            core_bus.cyc = 1'b1; core_bus.stb = 1'b1; core_bus.we = w;
            core_bus.sel = s; core_bus.adr = a; core_bus.dat = d;
            #1;
            vectors++;
            if ({ram_bus.cyc, ram_bus.stb, ram_bus.we, ram_bus.sel, ram_bus.adr, ram_bus.dat} !== {2'b11, w, s, a, d}) begin
                miscompares++;
                $display("FAIL idle_passthrough: got adr %h sel %h dat %h we %b expected adr %h sel %h dat %h we %b",
                         ram_bus.adr, ram_bus.sel, ram_bus.dat, ram_bus.we, a, s, d, w);
            end
            core_idle();
            tick();
        end
        resp_en = 1'b1; ack_delay = 2;
        core_bus.cyc = 1'b1; core_bus.stb = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_bus.ack === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen || core_bus.ack !== 1'b1) begin
            miscompares++; $display("FAIL idle_ack_passthrough: got core_ack %b seen %0b expected 1", core_bus.ack, seen); end
        core_idle();
        tick();
    endtask

    task automatic test_erase_load();
        bit ok;
        start_session(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL erase_reach_load: got timeout expected LOAD"); end
        vectors++; if (log_q.size() != EW) begin miscompares++; $display("FAIL erase_count: got %0d expected %0d", log_q.size(), EW); end
        for (int i = 0; i < log_q.size() && i < EW; i++) begin
            vectors++;
            if (log_q[i] !== {1'b1, 4'hF, 24'(i), 32'h0}) begin
                miscompares++;
                $display("FAIL erase_word%0d: got we %b sel %h adr %h dat %h expected we 1 sel f adr %h dat 0",
                         i, log_q[i].we, log_q[i].sel, log_q[i].adr, log_q[i].dat, 24'(i));
            end
        end
        vectors++; if (dl_wait !== 1'b0 || core_hold !== 1'b1) begin
            miscompares++; $display("FAIL load_flags: got dl_wait %b core_hold %b expected 0 1", dl_wait, core_hold); end
    endtask

    task automatic test_load_write();
        bit             ok;
        logic [15:0]    exp_half[int];
        logic [31:0]    obs_mem[int];
        logic [21:0]    a;
        logic [15:0]    d;
        logic [31:0]    word;
        logic [15:0]    got;
        int             w;
        log_q.delete();
        dl_addr = 22'h6; dl_data = 16'hBEEF; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        vectors++; if (ram_bus.adr !== 24'h100001) begin miscompares++; $display("FAIL beef_adr: got %h expected 100001", ram_bus.adr); end
        vectors++; if (ram_bus.sel !== 4'b1100) begin miscompares++; $display("FAIL beef_sel: got %b expected 1100", ram_bus.sel); end
        vectors++; if (ram_bus.dat !== 32'hBEEFBEEF) begin miscompares++; $display("FAIL beef_dat: got %h expected beefbeef", ram_bus.dat); end
        vectors++; if (dl_wait !== 1'b1 || ram_bus.we !== 1'b1) begin
            miscompares++; $display("FAIL beef_wait: got dl_wait %b we %b expected 1 1", dl_wait, ram_bus.we); end
        wait_load(ok);
        vectors++; if (!ok || log_q.size() != 1) begin
            miscompares++; $display("FAIL beef_done: got ok %0b writes %0d expected 1 1", ok, log_q.size()); end

        log_q.delete();
        for (int i = 0; i < 10; i++) begin
            a = 22'($urandom_range(0, 31)) << 1;
            d = 16'($urandom);
            exp_half[int'(a >> 1)] = d;
            dl_addr = a; dl_data = d; dl_wr = 1'b1;
            tick();
            dl_wr = 1'b0;
            wait_load(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rand_write%0d_done: got timeout expected LOAD", i); end
        end
        vectors++; if (log_q.size() != 10) begin miscompares++; $display("FAIL rand_write_count: got %0d expected 10", log_q.size()); end
        foreach (log_q[i]) begin
            w = int'(log_q[i].adr);
            if (!obs_mem.exists(w)) obs_mem[w] = 32'h0;
            for (int b = 0; b < 4; b++)
                if (log_q[i].sel[b]) obs_mem[w][8*b +: 8] = log_q[i].dat[8*b +: 8];
        end
        foreach (exp_half[k]) begin
            w    = int'(RB) + (k >> 1);
            word = obs_mem.exists(w) ? obs_mem[w] : 32'hxxxxxxxx;
            got  = (k % 2 == 1) ? word[31:16] : word[15:0];
            vectors++;
            if (got !== exp_half[k]) begin
                miscompares++;
                $display("FAIL image_half%0d: got %h expected %h", k, got, exp_half[k]);
            end
        end
    endtask

    task automatic test_dropped_wr();
        bit          ok;
        logic [15:0] d1;
        log_q.delete();
        d1 = 16'($urandom);
        dl_addr = 22'($urandom); dl_data = d1; dl_wr = 1'b1;
        tick();
        dl_addr = 22'($urandom); dl_data = ~d1;
        tick();
        dl_wr = 1'b0;
        vectors++; if (dl_err !== 1'b1) begin miscompares++; $display("FAIL drop_err: got %b expected 1", dl_err); end
        wait_load(ok);
        vectors++; if (!ok || log_q.size() != 1) begin
            miscompares++; $display("FAIL drop_single_write: got ok %0b writes %0d expected 1 1", ok, log_q.size()); end
        else begin
            vectors++; if (log_q[0].dat !== {d1, d1}) begin
                miscompares++; $display("FAIL drop_data: got %h expected %h", log_q[0].dat, {d1, d1}); end
        end
    endtask

    task automatic test_finish();
        dl_active = 1'b0;
        tick();
        vectors++; if (ram_bus.cyc !== 1'b0 || ram_bus.stb !== 1'b0 || core_hold !== 1'b1 || dl_wait !== 1'b1) begin
            miscompares++; $display("FAIL finish_cycle: got cyc %b stb %b hold %b wait %b expected 0 0 1 1",
                                    ram_bus.cyc, ram_bus.stb, core_hold, dl_wait); end
        tick();
        vectors++; if (core_hold !== 1'b0 || dl_wait !== 1'b0) begin
            miscompares++; $display("FAIL finish_to_idle: got hold %b wait %b expected 0 0", core_hold, dl_wait); end
    endtask

    task automatic test_simultaneous();
        bit          ok;
        logic [21:0] a;
        logic [15:0] d;
        start_session(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL simul_session: got timeout expected LOAD"); end
        log_q.delete();
        a = 22'($urandom); d = 16'($urandom);
        dl_addr = a; dl_data = d; dl_wr = 1'b1; dl_active = 1'b0;
        tick();
        dl_wr = 1'b0;
        vectors++; if (ram_bus.we !== 1'b1 || ram_bus.stb !== 1'b1) begin
            miscompares++; $display("FAIL simul_write_active: got we %b stb %b expected 1 1", ram_bus.we, ram_bus.stb); end
        wait_idle(ok);
        vectors++; if (!ok || log_q.size() != 1) begin
            miscompares++; $display("FAIL simul_done: got ok %0b writes %0d expected 1 1", ok, log_q.size()); end
        else begin
            vectors++;
            if (log_q[0].adr !== RB + 24'(a >> 2) || log_q[0].dat !== {d, d} || log_q[0].sel !== (a[1] ? 4'hC : 4'h3)) begin
                miscompares++; $display("FAIL simul_write: got adr %h sel %h dat %h expected adr %h dat %h",
                                        log_q[0].adr, log_q[0].sel, log_q[0].dat, RB + 24'(a >> 2), {d, d}); end
        end
    endtask

    task automatic test_drain();
        bit          ok;
        bit          seen;
        logic [23:0] a;
        log_q.delete();
        resp_en = 1'b1; ack_delay = 5;
        a = 24'($urandom);
        core_bus.cyc = 1'b1; core_bus.stb = 1'b1; core_bus.we = 1'b0; core_bus.sel = 4'hF; core_bus.adr = a;
        dl_active = 1'b1;
        #1;
        vectors++; if (dl_wait !== 1'b1 || core_hold !== 1'b0) begin
            miscompares++; $display("FAIL drain_entry: got wait %b hold %b expected 1 0", dl_wait, core_hold); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_bus.ack === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen || core_hold !== 1'b0) begin
            miscompares++; $display("FAIL drain_core_ack: got seen %0b hold %b expected 1 0", seen, core_hold); end
        ack_delay = 2;
        tick();
        core_idle();
        vectors++; if (core_hold !== 1'b1 || ram_bus.adr !== 24'h0 || ram_bus.we !== 1'b1 || core_bus.ack !== 1'b0) begin
            miscompares++; $display("FAIL drain_to_erase: got hold %b adr %h we %b ack %b expected 1 000000 1 0",
                                    core_hold, ram_bus.adr, ram_bus.we, core_bus.ack); end
        wait_load(ok);
        vectors++; if (!ok || log_q.size() != EW + 1 || log_q[0].we !== 1'b0 || log_q[0].adr !== a) begin
            miscompares++; $display("FAIL drain_sequence: got ok %0b accesses %0d expected 1 %0d", ok, log_q.size(), EW + 1); end
        dl_active = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL drain_exit: got timeout expected IDLE"); end
    endtask

    task automatic test_abort_erase();
        bit          ok;
        bit          found;
        logic [23:0] a;
        log_q.delete();
        resp_en = 1'b1; ack_delay = 2;
        dl_active = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ram_bus.cyc === 1'b1 && ram_bus.adr === 24'h2) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL abort_reach_word2: got timeout expected adr 2"); end
        dl_active = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok || log_q.size() != 3) begin
            miscompares++; $display("FAIL abort_words: got ok %0b writes %0d expected 1 3", ok, log_q.size()); end
        else begin
            vectors++; if (log_q[2].adr !== 24'h2) begin miscompares++; $display("FAIL abort_last: got %h expected 000002", log_q[2].adr); end
        end
        a = 24'($urandom);
        core_bus.cyc = 1'b1; core_bus.stb = 1'b1; core_bus.adr = a;
        #1;
        vectors++; if (ram_bus.cyc !== 1'b1 || ram_bus.adr !== a) begin
            miscompares++; $display("FAIL abort_passthrough: got cyc %b adr %h expected 1 %h", ram_bus.cyc, ram_bus.adr, a); end
        core_idle();
        tick();
    endtask

    task automatic test_reset_write();
        bit ok;
        start_session(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstw_session: got timeout expected LOAD"); end
        resp_en = 1'b0;
        dl_addr = 22'($urandom); dl_data = 16'($urandom); dl_wr = 1'b1;
        tick();
        tick();
        dl_wr = 1'b0;
        vectors++; if (ram_bus.stb !== 1'b1 || dl_err !== 1'b1) begin
            miscompares++; $display("FAIL rstw_pre: got stb %b err %b expected 1 1", ram_bus.stb, dl_err); end
        reset = 1'b1; dl_active = 1'b0;
        @(posedge clk_sys);
        #1;
        vectors++; if ({ram_bus.cyc, ram_bus.stb, ram_bus.we} !== 3'b000 || ram_bus.sel !== 4'h0 || ram_bus.adr !== 24'h0 || ram_bus.dat !== 32'h0) begin
            miscompares++; $display("FAIL rstw_ram: got ctl %b sel %h adr %h dat %h expected all 0",
                                    {ram_bus.cyc, ram_bus.stb, ram_bus.we}, ram_bus.sel, ram_bus.adr, ram_bus.dat); end
        vectors++; if (dl_err !== 1'b0 || core_hold !== 1'b0 || dl_wait !== 1'b0) begin
            miscompares++; $display("FAIL rstw_flags: got err %b hold %b wait %b expected 0 0 0", dl_err, core_hold, dl_wait); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_erase_load();
        test_load_write();
        test_dropped_wr();
        test_finish();
        test_simultaneous();
        test_drain();
        test_abort_erase();
        test_reset_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
